mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_if.sv | 38 +++
 rtl/mem_stage.sv | 267 ++++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_if
// Description : Data-memory bus between the MEM stage (master) and the
//               memory (slave): request strobes, address, write data,
//               byte enables, read data and access-complete pulse.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_if;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_rdata;
  logic        mem_resp;

  modport master (
    output mem_read,
    output mem_write,
    output mem_address,
    output mem_wdata,
    output mem_byte_enable,
    input  mem_rdata,
    input  mem_resp
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  mem_address,
    input  mem_wdata,
    input  mem_byte_enable,
    output mem_rdata,
    output mem_resp
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : LC-3b MEM pipeline stage. Accepts one instruction from EX,
//               performs at most one data access (two with indirection),
//               stalls EX while busy, aborts with mem_err after TIMEOUT
//               cycles without mem_resp, and registers the result toward WB.
//               Optional feature macro: MEM_INDIRECT_EN (LDI/STI pointer
//               fetch through state ACC2).
// Revision    : 1.0 - initial release
// ============================================================================
package lc3b_pkg;
  typedef struct packed {
    logic [3:0] opcode;
    logic [2:0] dr;
    logic       ld_reg;
    logic       mem_read;
    logic       mem_write;
    logic       mem_byte;
    logic       mem_indirect;
  } lc3b_ipacket;
endpackage

module mem_stage
  import lc3b_pkg::*;
#(
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ex_valid,
  input  lc3b_ipacket ex_ipacket,
  input  logic [15:0] ex_alu,
  input  logic [15:0] ex_addr,
  input  logic [15:0] ex_sdata,
  input  logic [15:0] ex_br_addr,
  output logic        stall_out,
  mem_stage_if.master mem,
  output logic        wb_valid,
  output lc3b_ipacket wb_ipacket,
  output logic [15:0] wb_alu,
  output logic [15:0] wb_mem,
  output logic [15:0] wb_br_addr,
  output logic        mem_err
);

  localparam int                 c_cnt_w    = $clog2(TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  lc3b_ipacket        r_pkt;
  logic [15:0]        r_alu;
  logic [15:0]        r_addr;
  logic [15:0]        r_sdata;
  logic [15:0]        r_br;
  logic [c_cnt_w-1:0] r_count;

  logic w_ex_mem;
  logic w_ex_ind;
  logic w_hold_ind;
  logic w_req;
  logic w_resp;
  logic w_wait;
  logic w_expire;
  logic w_accept;
  logic w_pass;
  logic w_hop;
  logic w_issue;
  logic w_finish;
  logic w_abort;

  // Word accesses are forced to an even address; byte accesses keep it.
  function automatic logic [15:0] f_addr(input logic [15:0] a, input logic b);
    return b ? a : {a[15:1], 1'b0};
  endfunction

  function automatic logic [1:0] f_be(input logic a0, input logic b);
    return b ? (a0 ? 2'b10 : 2'b01) : 2'b11;
  endfunction

  // A byte store replicates the byte on both lanes; enables pick the lane.
  function automatic logic [15:0] f_wdata(input logic [15:0] s, input logic b);
    return b ? {s[7:0], s[7:0]} : s;
  endfunction

  function automatic logic [15:0] f_load(input logic [15:0] d, input logic a0, input logic b);
    logic [7:0] y;
    y = a0 ? d[15:8] : d[7:0];
    return b ? {{8{y[7]}}, y} : d;
  endfunction

  assign w_ex_mem = ex_ipacket.mem_read | ex_ipacket.mem_write;
`ifdef MEM_INDIRECT_EN
  assign w_ex_ind   = w_ex_mem & ex_ipacket.mem_indirect;
  assign w_hold_ind = r_pkt.mem_indirect;
`else
  assign w_ex_ind   = 1'b0;
  assign w_hold_ind = 1'b0;
`endif

  // A response only counts while a strobe is actually up, so mem_resp in
  // IDLE or in the turnaround cycle before the second access is ignored.
  assign w_req     = mem.mem_read | mem.mem_write;
  assign w_resp    = w_req & mem.mem_resp;
  assign w_wait    = (r_state != IDLE) & w_req & ~mem.mem_resp;
  assign w_expire  = w_wait & (r_count == c_cnt_last);
  assign stall_out = (r_state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and per-cycle action decode.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_pass       = 1'b0;
    w_hop        = 1'b0;
    w_issue      = 1'b0;
    w_finish     = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      IDLE: begin
        if (ex_valid) begin
          w_accept = 1'b1;
          if (w_ex_mem) begin
            w_state_next = ACC1;
          end else begin
            w_pass = 1'b1;
          end
        end
      end
      ACC1: begin
        if (w_resp) begin
          if (w_hold_ind) begin
            w_hop        = 1'b1;
            w_state_next = ACC2;
          end else begin
            w_finish     = 1'b1;
            w_state_next = IDLE;
          end
        end else if (w_expire) begin
          w_abort      = 1'b1;
          w_state_next = IDLE;
        end
      end
      ACC2: begin
        if (w_resp) begin
          w_finish     = 1'b1;
          w_state_next = IDLE;
        end else if (w_expire) begin
          w_abort      = 1'b1;
          w_state_next = IDLE;
        end else if (!w_req) begin
          w_issue = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Hold register, memory request registers, timeout counter and WB outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pkt               <= '0;
      r_alu               <= '0;
      r_addr              <= '0;
      r_sdata             <= '0;
      r_br                <= '0;
      r_count             <= '0;
      mem.mem_read        <= 1'b0;
      mem.mem_write       <= 1'b0;
      mem.mem_address     <= '0;
      mem.mem_wdata       <= '0;
      mem.mem_byte_enable <= '0;
      wb_valid            <= 1'b0;
      wb_ipacket          <= '0;
      wb_alu              <= '0;
      wb_mem              <= '0;
      wb_br_addr          <= '0;
      mem_err             <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      mem_err  <= 1'b0;

      if (w_accept) begin
        r_pkt   <= ex_ipacket;
        r_alu   <= ex_alu;
        r_addr  <= ex_addr;
        r_sdata <= ex_sdata;
        r_br    <= ex_br_addr;
        r_count <= '0;
        if (w_ex_ind) begin
          // Pointer fetch is always a word read, even for STI.
          mem.mem_read        <= 1'b1;
          mem.mem_write       <= 1'b0;
          mem.mem_address     <= {ex_addr[15:1], 1'b0};
          mem.mem_byte_enable <= 2'b11;
          mem.mem_wdata       <= ex_sdata;
        end else if (w_ex_mem) begin
          mem.mem_read        <= ex_ipacket.mem_read;
          mem.mem_write       <= ex_ipacket.mem_write;
          mem.mem_address     <= f_addr(ex_addr, ex_ipacket.mem_byte);
          mem.mem_byte_enable <= f_be(ex_addr[0], ex_ipacket.mem_byte);
          mem.mem_wdata       <= f_wdata(ex_sdata, ex_ipacket.mem_byte);
        end
      end

      if (w_pass) begin
        wb_valid   <= 1'b1;
        wb_ipacket <= ex_ipacket;
        wb_alu     <= ex_alu;
        wb_mem     <= '0;
        wb_br_addr <= ex_br_addr;
      end

      if (w_wait) begin
        r_count <= r_count + c_cnt_w'(1);
      end

      // Fetched pointer becomes the effective address; strobes drop for one
      // cycle before the real access is issued.
      if (w_hop) begin
        r_addr        <= mem.mem_rdata;
        r_count       <= '0;
        mem.mem_read  <= 1'b0;
        mem.mem_write <= 1'b0;
      end

      if (w_issue) begin
        mem.mem_read        <= r_pkt.mem_read;
        mem.mem_write       <= r_pkt.mem_write;
        mem.mem_address     <= f_addr(r_addr, r_pkt.mem_byte);
        mem.mem_byte_enable <= f_be(r_addr[0], r_pkt.mem_byte);
        mem.mem_wdata       <= f_wdata(r_sdata, r_pkt.mem_byte);
      end

      if (w_finish || w_abort) begin
        mem.mem_read  <= 1'b0;
        mem.mem_write <= 1'b0;
        wb_valid      <= 1'b1;
        wb_ipacket    <= r_pkt;
        wb_alu        <= r_alu;
        wb_br_addr    <= r_br;
        wb_mem        <= (w_finish && r_pkt.mem_read) ?
                         f_load(mem.mem_rdata, r_addr[0], r_pkt.mem_byte) : '0;
        mem_err       <= w_abort;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Self-checking bench for mem_stage. Directed scenarios plus
//               randomized instructions compared against a memory-array
//               reference model; memory latency is driven per access.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;
  import lc3b_pkg::*;

  localparam int TO = 8;
`ifdef MEM_INDIRECT_EN
  localparam bit c_ind = 1'b1;
`else
  localparam bit c_ind = 1'b0;
`endif

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b0;
  logic        ex_valid   = 1'b0;
  lc3b_ipacket ex_ipacket = '0;
  logic [15:0] ex_alu     = '0;
  logic [15:0] ex_addr    = '0;
  logic [15:0] ex_sdata   = '0;
  logic [15:0] ex_br_addr = '0;
  logic        stall_out;
  logic        wb_valid;
  lc3b_ipacket wb_ipacket;
  logic [15:0] wb_alu;
  logic [15:0] wb_mem;
  logic [15:0] wb_br_addr;
  logic        mem_err;

  mem_stage_if mif();

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ex_valid   (ex_valid),
    .ex_ipacket (ex_ipacket),
    .ex_alu     (ex_alu),
    .ex_addr    (ex_addr),
    .ex_sdata   (ex_sdata),
    .ex_br_addr (ex_br_addr),
    .stall_out  (stall_out),
    .mem        (mif),
    .wb_valid   (wb_valid),
    .wb_ipacket (wb_ipacket),
    .wb_alu     (wb_alu),
    .wb_mem     (wb_mem),
    .wb_br_addr (wb_br_addr),
    .mem_err    (mem_err)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  bit   [15:0] mem_arr [32768];
  logic [15:0] obs_mem, obs_alu, obs_addr, obs_wd;
  logic [1:0]  obs_be;
  logic        obs_err;
  int          obs_stall;

  function automatic logic [15:0] b16(input logic b);
    return {15'b0, b};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic lc3b_ipacket mk(input bit rd, input bit wr, input bit by, input bit ind);
    lc3b_ipacket p;
    p = lc3b_ipacket'(12'($urandom));
    p.mem_read     = rd;
    p.mem_write    = wr;
    p.mem_byte     = by;
    p.mem_indirect = ind;
    return p;
  endfunction

  // Presents one instruction, plays the memory with the given latencies
  // (-1 = never respond) and checks everything against the memory model.
  task automatic do_instr(input lc3b_ipacket pkt, input logic [15:0] alu, input logic [15:0] addr,
                          input logic [15:0] sdata, input logic [15:0] br, input int lat0, input int lat1);
    bit          is_mem, ind, aborted, done;
    int          n_acc, stall_cnt, exp_stall;
    logic [15:0] a_addr [2];
    logic [1:0]  a_be   [2];
    logic [15:0] a_wd   [2];
    logic [1:0]  a_stb  [2];
    logic [15:0] a_rd   [2];
    int          a_lat  [2];
    logic [15:0] eff, word, exp_mem;
    logic [7:0]  byt;

    is_mem = pkt.mem_read | pkt.mem_write;
    ind    = c_ind && pkt.mem_indirect && is_mem;
    chk("idle before accept", b16(stall_out), 16'd0);
    ex_valid = 1'b1; ex_ipacket = pkt; ex_alu = alu; ex_addr = addr; ex_sdata = sdata; ex_br_addr = br;
    @(negedge clk);
    ex_valid = 1'b0; ex_ipacket = lc3b_ipacket'(12'($urandom));
    ex_alu = 16'($urandom); ex_addr = 16'($urandom); ex_sdata = 16'($urandom); ex_br_addr = 16'($urandom);

    if (!is_mem) begin
      obs_alu = wb_alu;
      chk("alu wb_valid", b16(wb_valid), 16'd1);
      chk("alu wb_alu", wb_alu, alu);
      chk("alu wb_br_addr", wb_br_addr, br);
      chk("alu wb_ipacket", {4'b0, wb_ipacket}, {4'b0, pkt});
      chk("alu no strobe", {14'b0, mif.mem_read, mif.mem_write}, 16'd0);
      chk("alu no stall", b16(stall_out), 16'd0);
      @(negedge clk);
      chk("alu wb_valid pulse", b16(wb_valid), 16'd0);
      return;
    end

    n_acc = 0;
    eff   = addr;
    if (ind) begin
      a_addr[0] = {addr[15:1], 1'b0}; a_be[0] = 2'b11; a_stb[0] = 2'b10; a_wd[0] = '0;
      a_rd[0] = mem_arr[addr[15:1]]; a_lat[0] = lat0;
      eff   = a_rd[0];
      n_acc = 1;
    end
    a_addr[n_acc] = pkt.mem_byte ? eff : {eff[15:1], 1'b0};
    a_be[n_acc]   = pkt.mem_byte ? (eff[0] ? 2'b10 : 2'b01) : 2'b11;
    a_wd[n_acc]   = pkt.mem_byte ? {sdata[7:0], sdata[7:0]} : sdata;
    a_stb[n_acc]  = {pkt.mem_read, pkt.mem_write};
    a_rd[n_acc]   = mem_arr[eff[15:1]];
    a_lat[n_acc]  = ind ? lat1 : lat0;
    n_acc++;

    aborted = 1'b0; stall_cnt = 0; exp_stall = 0;
    for (int k = 0; k < n_acc && !aborted; k++) begin
      if (k == 1) begin
        chk("indirect gap strobes", {14'b0, mif.mem_read, mif.mem_write}, 16'd0);
        if (stall_out) stall_cnt++;
        exp_stall++;
        @(negedge clk);
      end
      done = 1'b0;
      for (int w = 0; w < TO && !done; w++) begin
        if (w == 0 && k == n_acc - 1) begin
          obs_addr = mif.mem_address; obs_be = mif.mem_byte_enable; obs_wd = mif.mem_wdata;
        end
        chk("strobes", {14'b0, mif.mem_read, mif.mem_write}, {14'b0, a_stb[k]});
        chk("mem_address", mif.mem_address, a_addr[k]);
        chk("mem_byte_enable", {14'b0, mif.mem_byte_enable}, {14'b0, a_be[k]});
        if (a_stb[k][0]) chk("mem_wdata", mif.mem_wdata, a_wd[k]);
        if (stall_out) stall_cnt++;
        exp_stall++;
        if (w == a_lat[k]) begin
          mif.mem_resp = 1'b1; mif.mem_rdata = a_rd[k]; done = 1'b1;
        end else begin
          mif.mem_rdata = 16'($urandom);
        end
        @(negedge clk);
        mif.mem_resp = 1'b0;
      end
      if (!done) aborted = 1'b1;
    end

    if (aborted) begin
      exp_mem = '0;
    end else if (pkt.mem_read) begin
      word    = a_rd[n_acc-1];
      byt     = eff[0] ? word[15:8] : word[7:0];
      exp_mem = pkt.mem_byte ? 16'($signed(byt)) : word;
    end else begin
      exp_mem = '0;
      if (!pkt.mem_byte)  mem_arr[eff[15:1]]       = sdata;
      else if (eff[0])    mem_arr[eff[15:1]][15:8] = sdata[7:0];
      else                mem_arr[eff[15:1]][7:0]  = sdata[7:0];
    end

    obs_mem = wb_mem; obs_err = mem_err; obs_stall = stall_cnt;
    chk("mem wb_valid", b16(wb_valid), 16'd1);
    chk("mem wb_mem", wb_mem, exp_mem);
    chk("mem wb_alu", wb_alu, alu);
    chk("mem wb_br_addr", wb_br_addr, br);
    chk("mem wb_ipacket", {4'b0, wb_ipacket}, {4'b0, pkt});
    chk("mem_err", b16(mem_err), b16(aborted));
    chk("strobes dropped", {14'b0, mif.mem_read, mif.mem_write}, 16'd0);
    chk("stall released", b16(stall_out), 16'd0);
    chk("stall cycles", 16'(stall_cnt), 16'(exp_stall));
    @(negedge clk);
    chk("wb_valid pulse", b16(wb_valid), 16'd0);
    chk("mem_err pulse", b16(mem_err), 16'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded 500000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int r, l0, l1;
    bit rd, by;
    mif.mem_resp  = 1'b0;
    mif.mem_rdata = '0;
    for (int i = 0; i < 32768; i++) mem_arr[i] = 16'($urandom);

    // Reset values
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset stall_out", b16(stall_out), 16'd0);
    chk("reset strobes", {14'b0, mif.mem_read, mif.mem_write}, 16'd0);
    chk("reset wb_valid", b16(wb_valid), 16'd0);
    chk("reset mem_err", b16(mem_err), 16'd0);
    chk("reset wb_alu", wb_alu, 16'd0);
    chk("reset mem_address", mif.mem_address, 16'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // mem_resp while idle must do nothing
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      mif.mem_resp = 1'b1; mif.mem_rdata = 16'($urandom);
      @(negedge clk);
      if (wb_valid || stall_out || mif.mem_read || mif.mem_write || mem_err) bad++;
    end
    mif.mem_resp = 1'b0;
    chk("idle resp ignored", 16'(bad), 16'd0);

    // ADD
    do_instr(mk(0, 0, 0, 0), 16'h1234, 16'($urandom), 16'($urandom), 16'($urandom), 0, 0);
    chk("add wb_alu", obs_alu, 16'h1234);

    // LDB, high byte, response after 3 wait cycles
    mem_arr[16'h3001 >> 1] = 16'h80FF;
    do_instr(mk(1, 0, 1, 0), 16'($urandom), 16'h3001, 16'($urandom), 16'($urandom), 3, 0);
    chk("ldb byte_enable", {14'b0, obs_be}, 16'h0002);
    chk("ldb wb_mem", obs_mem, 16'hFF80);
    chk("ldb stall cycles", 16'(obs_stall), 16'd4);

    // STB, low byte
    do_instr(mk(0, 1, 1, 0), 16'($urandom), 16'h3000, 16'h00AB, 16'($urandom), 2, 0);
    chk("stb wdata", obs_wd, 16'hABAB);
    chk("stb byte_enable", {14'b0, obs_be}, 16'h0001);
    chk("stb wb_mem", obs_mem, 16'h0000);

    // LDR that never gets a response
    do_instr(mk(1, 0, 0, 0), 16'($urandom), 16'h2222, 16'($urandom), 16'($urandom), -1, 0);
    chk("timeout mem_err", b16(obs_err), 16'd1);
    chk("timeout wb_mem", obs_mem, 16'h0000);
    chk("timeout stall cycles", 16'(obs_stall), 16'(TO));

    // LDI through a pointer
    mem_arr[16'h4000 >> 1] = 16'h5000;
    mem_arr[16'h5000 >> 1] = 16'hBEEF;
    do_instr(mk(1, 0, 0, 1), 16'($urandom), 16'h4000, 16'($urandom), 16'($urandom), 1, 2);
`ifdef MEM_INDIRECT_EN
    chk("ldi second address", obs_addr, 16'h5000);
    chk("ldi wb_mem", obs_mem, 16'hBEEF);
`else
    chk("ldi flag ignored address", obs_addr, 16'h4000);
    chk("ldi flag ignored wb_mem", obs_mem, 16'h5000);
`endif

    // Randomized instruction mix
    for (int n = 0; n < 60; n++) begin
      r  = int'($urandom_range(0, 2));
      rd = $urandom_range(0, 1) == 1;
      by = $urandom_range(0, 1) == 1;
      l0 = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 5));
      l1 = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 5));
      do_instr(mk(r != 0 && rd, r != 0 && !rd, by, $urandom_range(0, 1) == 1),
               16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), l0, l1);
    end

    // Reset in the middle of an access
    ex_valid = 1'b1; ex_ipacket = mk(1, 0, 0, 0); ex_addr = 16'h1234;
    ex_alu = 16'h5555; ex_br_addr = 16'h6666;
    @(negedge clk);
    ex_valid = 1'b0;
    chk("pre-reset mem_read", b16(mif.mem_read), 16'd1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async reset mem_read", b16(mif.mem_read), 16'd0);
    chk("async reset stall_out", b16(stall_out), 16'd0);
    chk("async reset mem_address", mif.mem_address, 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      mif.mem_resp = $urandom_range(0, 1) == 1;
      @(negedge clk);
      if (wb_valid || mem_err || stall_out || mif.mem_read) bad++;
    end
    mif.mem_resp = 1'b0;
    chk("reset abandons access", 16'(bad), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
